// File: rtl/display_pkg.sv
// Seven-segment encoding shared by the display driver and the scan decoder.
// Patterns are active-high, bit 0 = segment a through bit 6 = segment g.
package display_pkg;

  localparam int SEG_W = 7;
  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;

  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h00;

  function automatic logic [SEG_W-1:0] hex_to_seg(input logic [3:0] hex);
    logic [SEG_W-1:0] pat;
    case (hex)
      4'h0: pat = 7'h3F;
      4'h1: pat = 7'h06;
      4'h2: pat = 7'h5B;
      4'h3: pat = 7'h4F;
      4'h4: pat = 7'h66;
      4'h5: pat = 7'h6D;
      4'h6: pat = 7'h7D;
      4'h7: pat = 7'h07;
      4'h8: pat = 7'h7F;
      4'h9: pat = 7'h6F;
      4'hA: pat = 7'h77;
      4'hB: pat = 7'h7C;  // lower-case b
      4'hC: pat = 7'h39;
      4'hD: pat = 7'h5E;  // lower-case d
      4'hE: pat = 7'h79;
      default: pat = 7'h71;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/seg_glyph_decode.sv
// Combinational reverse lookup of an active-high segment pattern into a hex
// digit; the all-off pattern is reported as a valid blank.
module seg_glyph_decode
  import display_pkg::*;
(
  input  logic [SEG_W-1:0] seg_i,
  output logic             valid_o,
  output logic             blank_o,
  output logic [3:0]       hex_o
);

  always_comb begin
    valid_o = 1'b0;
    blank_o = 1'b0;
    hex_o   = 4'h0;
    if (seg_i == SEG_BLANK) begin
      valid_o = 1'b1;
      blank_o = 1'b1;
    end else begin
      for (int i = 0; i < 16; i++) begin
        if (seg_i == hex_to_seg(4'(i))) begin
          valid_o = 1'b1;
          hex_o   = 4'(i);
        end
      end
    end
  end

endmodule

// File: rtl/seg_scan_decoder.sv
// Monitors a multiplexed seven-segment bus, captures each anode slot once it
// has settled and publishes a coherent multi-digit snapshot per frame.
module seg_scan_decoder
  import display_pkg::*;
#(
  parameter int unsigned NUM_DIGITS     = 4,
  parameter int unsigned SETTLE_CYCLES  = 8,
  parameter bit          SEG_ACTIVE_LOW = 1'b1,
  parameter bit          AN_ACTIVE_LOW  = 1'b1
) (
  input  logic                    clk,
  input  logic                    resetBtn_n,
  input  logic [SEG_W-1:0]        seg_in,
  input  logic [NUM_DIGITS-1:0]   an_in,
  output logic [4*NUM_DIGITS-1:0] digit_out,
  output logic [NUM_DIGITS-1:0]   blank_out,
  output logic                    frame_done,
  output logic                    changed,
  output logic                    decode_err,
  output logic                    anode_err
);

  localparam int SLOT_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [7:0] SETTLE_N = 8'(SETTLE_CYCLES);
  localparam logic [NUM_DIGITS-1:0] AN_ONE  = NUM_DIGITS'(1);
  localparam logic [NUM_DIGITS-1:0] AN_IDLE = AN_ACTIVE_LOW ? '1 : '0;
  localparam logic [SEG_W-1:0]      SEG_IDLE = SEG_ACTIVE_LOW ? '1 : '0;

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_CAPTURE, S_HOLD} state_e;

  logic [SEG_W-1:0]      seg_s1_q, seg_s2_q;
  logic [NUM_DIGITS-1:0] an_s1_q, an_s2_q;
  logic [SEG_W-1:0]      seg_n;
  logic [NUM_DIGITS-1:0] an_n;
  logic                  an_multi, an_onehot;
  logic [SLOT_W-1:0]     slot_idx;

  state_e                state_q, state_d;
  logic [7:0]            cnt_q, cnt_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [SLOT_W-1:0]     slot_q, slot_d;
  logic [SEG_W-1:0]      seg_q, seg_d;
  logic                  restart;

  logic                  capture_en, frame_cmt;
  logic [NUM_DIGITS-1:0] seen_q, seen_d;
  logic [NUM_DIGITS-1:0][3:0] shadow_dig_q, digit_q;
  logic [NUM_DIGITS-1:0] shadow_blank_q, blank_q;
  logic                  frame_done_q, changed_q, decode_err_q, anode_err_q;

  logic                  g_valid, g_blank;
  logic [3:0]            g_hex;

  // Synchronisers idle at the inactive bus level so reset release is quiet
  always_ff @(posedge clk or negedge resetBtn_n) begin
    if (!resetBtn_n) begin
      seg_s1_q <= SEG_IDLE;
      seg_s2_q <= SEG_IDLE;
      an_s1_q  <= AN_IDLE;
      an_s2_q  <= AN_IDLE;
    end else begin
      seg_s1_q <= seg_in;
      seg_s2_q <= seg_s1_q;
      an_s1_q  <= an_in;
      an_s2_q  <= an_s1_q;
    end
  end

  assign seg_n     = SEG_ACTIVE_LOW ? ~seg_s2_q : seg_s2_q;
  assign an_n      = AN_ACTIVE_LOW  ? ~an_s2_q  : an_s2_q;
  assign an_multi  = |(an_n & (an_n - AN_ONE));
  assign an_onehot = (an_n != '0) && !an_multi;

  always_comb begin
    slot_idx = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (an_n[i]) slot_idx = SLOT_W'(i);
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge resetBtn_n) begin
    if (!resetBtn_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      an_q    <= '0;
      slot_q  <= '0;
      seg_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      an_q    <= an_d;
      slot_q  <= slot_d;
      seg_q   <= seg_d;
    end
  end

  // FSM next state; restart re-evaluates the current sample as if idle
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    an_d    = an_q;
    slot_d  = slot_q;
    seg_d   = seg_q;
    restart = 1'b0;
    case (state_q)
      S_IDLE:    restart = 1'b1;
      S_SETTLE: begin
        if (an_n == an_q && seg_n == seg_q) begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_d == SETTLE_N) state_d = S_CAPTURE;
        end else begin
          restart = 1'b1;
        end
      end
      S_CAPTURE: state_d = S_HOLD;
      S_HOLD:    if (an_n != an_q) restart = 1'b1;
      default:   state_d = S_IDLE;
    endcase
    if (restart) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      if (an_onehot) begin
        an_d    = an_n;
        slot_d  = slot_idx;
        seg_d   = seg_n;
        cnt_d   = 8'd1;
        state_d = (SETTLE_N == 8'd1) ? S_CAPTURE : S_SETTLE;
      end
    end
  end

  seg_glyph_decode u_glyph (
    .seg_i   (seg_q),
    .valid_o (g_valid),
    .blank_o (g_blank),
    .hex_o   (g_hex)
  );

  // FSM outputs and frame bookkeeping
  always_comb begin
    capture_en = (state_q == S_CAPTURE);
    frame_cmt  = &seen_q;
    seen_d     = frame_cmt ? '0 : seen_q;
    if (capture_en && g_valid) seen_d[slot_q] = 1'b1;
  end

  always_ff @(posedge clk or negedge resetBtn_n) begin
    if (!resetBtn_n) begin
      seen_q         <= '0;
      shadow_dig_q   <= '0;
      shadow_blank_q <= '0;
      digit_q        <= '0;
      blank_q        <= '0;
      frame_done_q   <= 1'b0;
      changed_q      <= 1'b0;
      decode_err_q   <= 1'b0;
      anode_err_q    <= 1'b0;
    end else begin
      seen_q       <= seen_d;
      frame_done_q <= frame_cmt;
      changed_q    <= frame_cmt &&
                      ({shadow_dig_q, shadow_blank_q} != {digit_q, blank_q});
      decode_err_q <= capture_en && !g_valid;
      anode_err_q  <= an_multi;
      if (frame_cmt) begin
        digit_q <= shadow_dig_q;
        blank_q <= shadow_blank_q;
      end
      // A blank capture keeps the previous digit value in the shadow
      if (capture_en && g_valid) begin
        shadow_blank_q[slot_q] <= g_blank;
        if (!g_blank) shadow_dig_q[slot_q] <= g_hex;
      end
    end
  end

  assign digit_out  = digit_q;
  assign blank_out  = blank_q;
  assign frame_done = frame_done_q;
  assign changed    = changed_q;
  assign decode_err = decode_err_q;
  assign anode_err  = anode_err_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed bench for seg_scan_decoder: drives anode/segment scans and checks
// the published snapshots and error pulses against hand-computed values.
module tb_seg_scan_decoder;

  logic        clk;
  logic        resetBtn_n;
  logic [6:0]  seg_in;
  logic [3:0]  an_in;
  logic [15:0] digit_out;
  logic [3:0]  blank_out;
  logic        frame_done, changed, decode_err, anode_err;

  int n_tests = 0;
  int n_fail  = 0;
  int fd_cnt = 0, derr_cnt = 0, aerr_cnt = 0, stray_chg = 0;
  logic [15:0] last_digit = '0;
  logic [3:0]  last_blank = '0;
  logic        last_changed = 1'b0;

  // Active-low glyphs for the bus
  localparam logic [6:0] G0 = 7'h40, G1 = 7'h79, G3 = 7'h30, GA = 7'h08;
  localparam logic [6:0] G4 = 7'h19, G5 = 7'h12, G8 = 7'h00, GF = 7'h0E;
  localparam logic [6:0] GB = 7'h03, GD = 7'h21, GOFF = 7'h7F, GBAD = 7'h7E;

  seg_scan_decoder dut (
    .clk        (clk),
    .resetBtn_n (resetBtn_n),
    .seg_in     (seg_in),
    .an_in      (an_in),
    .digit_out  (digit_out),
    .blank_out  (blank_out),
    .frame_done (frame_done),
    .changed    (changed),
    .decode_err (decode_err),
    .anode_err  (anode_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_done) begin
      fd_cnt       <= fd_cnt + 1;
      last_digit   <= digit_out;
      last_blank   <= blank_out;
      last_changed <= changed;
    end
    if (changed && !frame_done) stray_chg <= stray_chg + 1;
    if (decode_err) derr_cnt <= derr_cnt + 1;
    if (anode_err)  aerr_cnt <= aerr_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic visit(input logic [3:0] an, input logic [6:0] seg, input int n);
    an_in  = an;
    seg_in = seg;
    repeat (n) @(negedge clk);
  endtask

  task automatic gap();
    visit(4'hF, GOFF, 8);
  endtask

  initial begin
    resetBtn_n = 1'b0;
    seg_in     = 7'h55;
    an_in      = 4'h3;
    repeat (3) @(negedge clk);
    chk("rst_digit", 32'(digit_out), 32'h0);
    chk("rst_blank", 32'(blank_out), 32'h0);
    chk("rst_fd",    32'(frame_done), 32'h0);
    chk("rst_chg",   32'(changed), 32'h0);
    chk("rst_derr",  32'(decode_err), 32'h0);
    chk("rst_aerr",  32'(anode_err), 32'h0);

    an_in = 4'hF; seg_in = GOFF;
    @(negedge clk);
    resetBtn_n = 1'b1;
    repeat (50) @(negedge clk);
    chk("idle_fd",   32'(fd_cnt), 32'd0);
    chk("idle_derr", 32'(derr_cnt), 32'd0);
    chk("idle_aerr", 32'(aerr_cnt), 32'd0);

    // Clean frame "0","1","3","A"
    visit(4'hE, G0, 20); visit(4'hD, G1, 20); visit(4'hB, G3, 20); visit(4'h7, GA, 20);
    gap();
    chk("f1_cnt",   32'(fd_cnt), 32'd1);
    chk("f1_digit", 32'(last_digit), 32'hA310);
    chk("f1_blank", 32'(last_blank), 32'h0);
    chk("f1_chg",   32'(last_changed), 32'd1);
    chk("f1_live",  32'(digit_out), 32'hA310);

    // Identical frame
    visit(4'hE, G0, 20); visit(4'hD, G1, 20); visit(4'hB, G3, 20); visit(4'h7, GA, 20);
    gap();
    chk("f2_cnt", 32'(fd_cnt), 32'd2);
    chk("f2_chg", 32'(last_changed), 32'd0);

    // Short dwell on slot 1 must not capture
    visit(4'hE, G1, 20); visit(4'hD, G4, 5); visit(4'hB, G3, 20); visit(4'h7, GA, 20);
    gap();
    chk("short_nofd", 32'(fd_cnt), 32'd2);
    visit(4'hD, G0, 20);
    gap();
    chk("short_cnt",   32'(fd_cnt), 32'd3);
    chk("short_digit", 32'(last_digit), 32'hA301);
    chk("short_chg",   32'(last_changed), 32'd1);

    // Segment glitch mid-settle on slot 2: the later pattern wins
    visit(4'hE, G0, 20); visit(4'hD, G1, 20);
    visit(4'hB, G3, 5);  visit(4'hB, G5, 12);
    visit(4'h7, GA, 20);
    gap();
    chk("glitch_cnt",   32'(fd_cnt), 32'd4);
    chk("glitch_digit", 32'(last_digit), 32'hA510);

    // Unmatched pattern and multi-hot anode
    visit(4'hE, G0, 20); visit(4'hD, GBAD, 20); visit(4'hB, G3, 20); visit(4'h7, GA, 20);
    gap();
    chk("derr_cnt",  32'(derr_cnt), 32'd1);
    chk("derr_nofd", 32'(fd_cnt), 32'd4);
    visit(4'hC, G1, 3);
    gap();
    chk("aerr_cnt", 32'(aerr_cnt), 32'd3);
    visit(4'hD, G1, 20);
    gap();
    chk("err_cnt",   32'(fd_cnt), 32'd5);
    chk("err_digit", 32'(last_digit), 32'hA310);
    chk("err_chg",   32'(last_changed), 32'd1);

    // Dark slot 3
    visit(4'hE, G0, 20); visit(4'hD, G1, 20); visit(4'hB, G3, 20); visit(4'h7, GOFF, 20);
    gap();
    chk("blank_cnt",   32'(fd_cnt), 32'd6);
    chk("blank_mask",  32'(last_blank), 32'h8);
    chk("blank_digit", 32'(last_digit), 32'hA310);
    chk("blank_chg",   32'(last_changed), 32'd1);

    // Reset after two slots discards the partial frame
    visit(4'hE, G1, 20); visit(4'hD, G3, 20);
    resetBtn_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("mrst_digit", 32'(digit_out), 32'h0);
    chk("mrst_blank", 32'(blank_out), 32'h0);
    resetBtn_n = 1'b1;
    gap();
    visit(4'hB, GB, 20); visit(4'h7, GD, 20);
    gap();
    chk("mrst_nofd", 32'(fd_cnt), 32'd6);
    visit(4'hE, G8, 20); visit(4'hD, GF, 20);
    gap();
    chk("mrst_cnt",   32'(fd_cnt), 32'd7);
    chk("mrst_digit2", 32'(last_digit), 32'hDBF8);
    chk("mrst_blank2", 32'(last_blank), 32'h0);
    chk("mrst_chg",   32'(last_changed), 32'd1);

    chk("stray_changed", 32'(stray_chg), 32'd0);
    chk("final_aerr",    32'(aerr_cnt), 32'd3);
    chk("final_derr",    32'(derr_cnt), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
